// File: rtl/pipeline_input_window_fsm_if.sv
// Handshake bundle for the pipeline input-window sequencer: requests in, enable/status out.
interface pipeline_input_window_fsm_if #(
  parameter int unsigned CNT_W = 4
);
  logic             init_OPERATION;
  logic             stall;
  logic             abort;
  logic             enable_Pipeline_input;
  logic             busy;
  logic             window_done;
  logic [CNT_W-1:0] phase_cnt;

  modport master (
    output init_OPERATION,
    output stall,
    output abort,
    input  enable_Pipeline_input,
    input  busy,
    input  window_done,
    input  phase_cnt
  );

  modport slave (
    input  init_OPERATION,
    input  stall,
    input  abort,
    output enable_Pipeline_input,
    output busy,
    output window_done,
    output phase_cnt
  );
endinterface

// File: rtl/pipeline_input_window_fsm.sv
// Input-enable sequencer: opens an EN_CYCLES window on an accepted request, then holds the
// pipeline input closed for HOLD_CYCLES cycles; supports stall freeze and synchronous abort.
module pipeline_input_window_fsm #(
  parameter int unsigned EN_CYCLES   = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned GATE_INIT   = 1
) (
  input logic                         clk,
  input logic                         rst,
  pipeline_input_window_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StEnable = 2'd1,
    StHold   = 2'd2
  } state_e;

  localparam bit HasEnable = (EN_CYCLES > 1);
  localparam bit HasHold   = (HOLD_CYCLES > 0);
  localparam logic [CNT_W-1:0] EnLast   = HasEnable ? CNT_W'(EN_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] HoldLast = HasHold ? CNT_W'(HOLD_CYCLES - 1) : '0;

  state_e           r_state;
  state_e           w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_window;
  logic             w_done;
  logic             w_init_gate;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_window  = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      StIdle: begin
        w_window = bus.init_OPERATION & ~bus.stall;
        if (bus.init_OPERATION && !bus.stall) begin
          w_cnt_d = '0;
          if (HasEnable) begin
            w_state_d = StEnable;
          end else if (HasHold) begin
            w_state_d = StHold;
          end
        end
      end
      StEnable: begin
        w_window = ~bus.stall;
        if (!bus.stall) begin
          if (r_cnt == EnLast) begin
            w_cnt_d = '0;
            if (HasHold) begin
              w_state_d = StHold;
            end else begin
              // No hold phase: the last enable cycle completes the window.
              w_state_d = StIdle;
              w_done    = 1'b1;
            end
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
      end
      StHold: begin
        if (!bus.stall) begin
          if (r_cnt == HoldLast) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_done    = 1'b1;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
    if (bus.abort) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
      w_done    = 1'b0;
    end
  end

  assign w_init_gate = (GATE_INIT != 0) ? bus.init_OPERATION : 1'b1;

  // Mealy enable is forced low by reset so it cannot follow the request during reset.
  assign bus.enable_Pipeline_input = w_window & w_init_gate & rst;
  assign bus.busy                  = (r_state != StIdle);
  assign bus.window_done           = w_done;
  assign bus.phase_cnt             = r_cnt;

endmodule

// File: tb/tb_pipeline_input_window_fsm.sv
// Bench for pipeline_input_window_fsm: five parameter sets against a window-position model,
// with literal scenario patterns and randomized request/stall/abort/reset traffic.
module tb_pipeline_input_window_fsm;
  localparam int NCFG = 5;

  logic clk = 1'b0;
  logic rst;
  logic init;
  logic stall;
  logic abort;
  logic chk_on = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  int cfg_en   [NCFG] = '{3, 5, 5, 1, 1};
  int cfg_hold [NCFG] = '{4, 2, 2, 0, 3};
  int cfg_gate [NCFG] = '{1, 0, 1, 1, 1};

  // Model: 0 = idle, otherwise 1-based position within the EN+HOLD cycle window.
  int mpos [NCFG] = '{0, 0, 0, 0, 0};

  logic [NCFG-1:0] dut_en;
  logic [NCFG-1:0] dut_busy;
  logic [NCFG-1:0] dut_done;
  logic [3:0]      dut_pc [NCFG];

  always #5 clk = ~clk;

  pipeline_input_window_fsm_if #(.CNT_W(4)) if0 ();
  pipeline_input_window_fsm_if #(.CNT_W(4)) if1 ();
  pipeline_input_window_fsm_if #(.CNT_W(4)) if2 ();
  pipeline_input_window_fsm_if #(.CNT_W(4)) if3 ();
  pipeline_input_window_fsm_if #(.CNT_W(4)) if4 ();

  pipeline_input_window_fsm #(.EN_CYCLES(3), .HOLD_CYCLES(4), .CNT_W(4), .GATE_INIT(1))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  pipeline_input_window_fsm #(.EN_CYCLES(5), .HOLD_CYCLES(2), .CNT_W(4), .GATE_INIT(0))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  pipeline_input_window_fsm #(.EN_CYCLES(5), .HOLD_CYCLES(2), .CNT_W(4), .GATE_INIT(1))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  pipeline_input_window_fsm #(.EN_CYCLES(1), .HOLD_CYCLES(0), .CNT_W(4), .GATE_INIT(1))
    u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  pipeline_input_window_fsm #(.EN_CYCLES(1), .HOLD_CYCLES(3), .CNT_W(4), .GATE_INIT(1))
    u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  assign if0.init_OPERATION = init;
  assign if1.init_OPERATION = init;
  assign if2.init_OPERATION = init;
  assign if3.init_OPERATION = init;
  assign if4.init_OPERATION = init;
  assign if0.stall = stall;
  assign if1.stall = stall;
  assign if2.stall = stall;
  assign if3.stall = stall;
  assign if4.stall = stall;
  assign if0.abort = abort;
  assign if1.abort = abort;
  assign if2.abort = abort;
  assign if3.abort = abort;
  assign if4.abort = abort;

  assign dut_en   = {if4.enable_Pipeline_input, if3.enable_Pipeline_input,
                     if2.enable_Pipeline_input, if1.enable_Pipeline_input,
                     if0.enable_Pipeline_input};
  assign dut_busy = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
  assign dut_done = {if4.window_done, if3.window_done, if2.window_done, if1.window_done,
                     if0.window_done};
  assign dut_pc[0] = if0.phase_cnt;
  assign dut_pc[1] = if1.phase_cnt;
  assign dut_pc[2] = if2.phase_cnt;
  assign dut_pc[3] = if3.phase_cnt;
  assign dut_pc[4] = if4.phase_cnt;

  task automatic chk(input string nm, input int c, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cfg%0d t=%0t got=%0h expected=%0h", nm, c, $time, act, exp);
    end
  endtask

  function automatic void model_out(input int c, output logic en, output logic busy,
                                    output logic done, output logic [3:0] pc);
    int p;
    int ln;
    logic win;
    p  = mpos[c];
    ln = cfg_en[c] + cfg_hold[c];
    if (!rst) begin
      en = 0; busy = 0; done = 0; pc = 0;
      return;
    end
    win  = (p == 0) ? (init & ~stall) : ((p < cfg_en[c]) && !stall);
    en   = win & ((cfg_gate[c] != 0) ? init : 1'b1);
    busy = (p != 0);
    done = (p != 0) && (p == ln - 1) && !stall && !abort;
    if (p == 0)              pc = 0;
    else if (p < cfg_en[c])  pc = 4'(p - 1);
    else                     pc = 4'(p - cfg_en[c]);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCFG; c++) mpos[c] <= 0;
    end else begin
      for (int c = 0; c < NCFG; c++) begin
        if (abort)            mpos[c] <= 0;
        else if (stall)       mpos[c] <= mpos[c];
        else if (mpos[c] == 0) mpos[c] <= (init && (cfg_en[c] + cfg_hold[c] > 1)) ? 1 : 0;
        else                  mpos[c] <= (mpos[c] + 1 == cfg_en[c] + cfg_hold[c]) ? 0
                                         : mpos[c] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int c = 0; c < NCFG; c++) begin
        logic e_en, e_busy, e_done;
        logic [3:0] e_pc;
        model_out(c, e_en, e_busy, e_done, e_pc);
        chk("model_en",   c, {3'b0, dut_en[c]},   {3'b0, e_en});
        chk("model_busy", c, {3'b0, dut_busy[c]}, {3'b0, e_busy});
        chk("model_done", c, {3'b0, dut_done[c]}, {3'b0, e_done});
        chk("model_pc",   c, dut_pc[c],           e_pc);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; init = 1'b1; stall = 1'b0; abort = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      chk("rst_en",   c, {3'b0, dut_en[c]},   4'd0);
      chk("rst_busy", c, {3'b0, dut_busy[c]}, 4'd0);
      chk("rst_done", c, {3'b0, dut_done[c]}, 4'd0);
      chk("rst_pc",   c, dut_pc[c],           4'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_dir(input string nm, input int c, input int n, input logic [15:0] iv,
                         input logic [15:0] sv, input logic [15:0] av, input logic [15:0] xen,
                         input logic [15:0] xdone, input logic [15:0] xbusy);
    do_reset();
    for (int i = 0; i < n; i++) begin
      init = iv[i]; stall = sv[i]; abort = av[i];
      @(negedge clk);
      chk({nm, "_en"},   c, {3'b0, dut_en[c]},   {3'b0, xen[i]});
      chk({nm, "_done"}, c, {3'b0, dut_done[c]}, {3'b0, xdone[i]});
      chk({nm, "_busy"}, c, {3'b0, dut_busy[c]}, {3'b0, xbusy[i]});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; stall = 1'b0; abort = 1'b0;
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
    run_dir("defaults", 0, 14, 16'hFFFF, 16'h0000, 16'h0000, 16'h0387, 16'h2040, 16'h3F7E);
    run_dir("pulse_g0", 1, 8,  16'h0001, 16'h0000, 16'h0000, 16'h001F, 16'h0040, 16'h007E);
    run_dir("pulse_g1", 2, 8,  16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0040, 16'h007E);
    run_dir("stall",    0, 10, 16'hFFFF, 16'h0006, 16'h0000, 16'h0219, 16'h0100, 16'h01FE);
    run_dir("abort",    0, 8,  16'hFFFF, 16'h0000, 16'h0010, 16'h00E7, 16'h0000, 16'h00DE);
    run_dir("en1_h0",   3, 16, 16'hA5C3, 16'h0000, 16'h0000, 16'hA5C3, 16'h0000, 16'h0000);
    run_dir("en1_h3",   4, 8,  16'hFFFF, 16'h0000, 16'h0000, 16'h0011, 16'h0088, 16'h00EE);
    run_dir("stall_tc", 0, 9,  16'hFFFF, 16'h0040, 16'h0000, 16'h0107, 16'h0080, 16'h00FE);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      init  = ($urandom_range(0, 9) < 7);
      stall = ($urandom_range(0, 99) < 15);
      abort = ($urandom_range(0, 99) < 5);
      rst   = ($urandom_range(0, 199) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
